// File: rtl/inst_loader_pkg.sv
// Shared types and defaults for the boot-time instruction loader.
//   addr_t / inst_t : 32-bit byte address and instruction word types
//   loader_state_t  : loader FSM states
//   InstStartFrom   : default byte address of the first loaded instruction
//   InstSpace       : default instruction memory size in bytes
//   LoaderHdrBytes  : bytes in the word-count header (and in every data word)
package inst_loader_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam addr_t       InstStartFrom  = 32'h0000_0000;
    localparam int unsigned InstSpace      = 1024;
    localparam int unsigned LoaderHdrBytes = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Little-endian byte-to-word assembler, shared by the header and data phases.
//   clk, rst     : clock, synchronous active-high reset
//   clear_i      : restart assembly (counter and shift register to zero)
//   shift_en_i   : byte_i is consumed this cycle
//   byte_i       : incoming byte
//   byte_cnt_o   : bytes already held for the current word (0..3)
//   word_full_o  : this cycle's byte completes the word
//   word_o       : word including this cycle's byte, so it is complete
//                  in the same cycle word_full_o is high
module word_assembler
    import inst_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       shift_en_i,
    input  logic [7:0] byte_i,
    output logic [1:0] byte_cnt_o,
    output logic       word_full_o,
    output inst_t      word_o
);

    logic [1:0] cnt_q, cnt_d;
    inst_t      sr_q,  sr_d;
    inst_t      shifted;

    // New bytes enter at the top, so the first byte ends up in [7:0].
    assign shifted = {byte_i, sr_q[31:8]};

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear_i) begin
            cnt_d = 2'd0;
            sr_d  = '0;
        end else if (shift_en_i) begin
            cnt_d = cnt_q + 2'd1;   // wraps to 0 after the last byte
            sr_d  = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign byte_cnt_o  = cnt_q;
    assign word_full_o = shift_en_i && (cnt_q == 2'(LoaderHdrBytes - 1));
    assign word_o      = shift_en_i ? shifted : sr_q;

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: parses a 4-byte little-endian word-count header
// from a valid/ready byte stream, then writes that many little-endian words
// into instruction memory, holding the core until the image is complete.
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a session (honoured in IDLE, DONE, ERR)
//   byte_valid/byte_data : byte stream in
//   byte_ready           : byte accepted when byte_valid && byte_ready
//   load/addr/load_inst  : one-cycle instruction memory write port
//   cpu_hold             : high while a session is in progress
//   done / error         : sticky completion / capacity-overflow status
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter addr_t       START_ADDR = InstStartFrom,
    parameter int unsigned SPACE      = InstSpace
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       load,
    output addr_t      addr,
    output inst_t      load_inst,
    output logic       cpu_hold,
    output logic       done,
    output logic       error
);

    localparam logic [31:0] CapWords = 32'(SPACE / 4);

    loader_state_t state_q, state_d;
    logic [31:0]   idx_q,   idx_d;     // index of the next word to write
    logic [31:0]   n_q,     n_d;       // word count from the header
    addr_t         addr_q,  addr_d;
    inst_t         inst_q,  inst_d;

    logic       xfer;
    logic       asm_clear;
    logic       asm_full;
    logic [1:0] asm_cnt;
    inst_t      asm_word;
    logic       unused_asm_cnt;

    assign xfer = byte_valid && byte_ready;

    word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (asm_clear),
        .shift_en_i  (xfer),
        .byte_i      (byte_data),
        .byte_cnt_o  (asm_cnt),
        .word_full_o (asm_full),
        .word_o      (asm_word)
    );

    // The byte count is a debug view; completion comes from asm_full.
    assign unused_asm_cnt = ^asm_cnt;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        asm_clear = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = HDR;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            HDR: begin
                if (asm_full) begin
                    n_d   = asm_word;
                    idx_d = '0;
                    if (asm_word == 32'd0)
                        state_d = DONE;
                    else if (asm_word > CapWords)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                // Write port registers are loaded here so they are valid for
                // the whole WRITE cycle and then hold.
                if (asm_full) begin
                    state_d = WRITE;
                    addr_d  = START_ADDR + (idx_q << 2);
                    inst_d  = asm_word;
                end
            end
            WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == n_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= START_ADDR;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
        end
    end

    assign byte_ready = (state_q == HDR) || (state_q == DATA);
    assign load       = (state_q == WRITE);
    assign cpu_hold   = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign addr       = addr_q;
    assign load_inst  = inst_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: cycle table for the nominal image, then
// hand-written sequences for gaps, zero/overflow headers, reset, restart
// and full capacity. A second instance (SPACE=16) covers capacity limits.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, byte_valid;
    logic [7:0] byte_data;

    logic  byte_ready, load, cpu_hold, done, error;
    addr_t addr;
    inst_t load_inst;

    logic  c_ready, c_load, c_hold, c_done, c_error;
    addr_t c_addr;
    inst_t c_inst;

    int checks   = 0;
    int failures = 0;

    addr_t wa[$];
    inst_t wd[$];
    addr_t ca[$];
    inst_t cd[$];
    logic  prev_ld  = 1'b0;
    logic  prev_cld = 1'b0;

    inst_loader #(.START_ADDR(32'h0), .SPACE(64)) u_dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .load(load),
        .addr(addr), .load_inst(load_inst), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    inst_loader #(.START_ADDR(32'h100), .SPACE(16)) u_cap (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(c_ready), .load(c_load),
        .addr(c_addr), .load_inst(c_inst), .cpu_hold(c_hold),
        .done(c_done), .error(c_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record every write and police the write-cycle rules.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            wa.push_back(addr);
            wd.push_back(load_inst);
            chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            chk("load_not_back_to_back", {31'd0, prev_ld}, 32'd0);
        end
        if (c_load === 1'b1) begin
            ca.push_back(c_addr);
            cd.push_back(c_inst);
            chk("cap_load_not_back_to_back", {31'd0, prev_cld}, 32'd0);
        end
        prev_ld  = load;
        prev_cld = c_load;
    end

    typedef struct {
        logic        s, v;
        logic [7:0]  d;
        logic [4:0]  flags;   // {byte_ready, load, cpu_hold, done, error}
        logic [31:0] a, i;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic [4:0] f, input logic [31:0] a, input logic [31:0] i);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.flags = f; r.a = a; r.i = i;
        vt.push_back(r);
    endtask

    function automatic logic [31:0] flags_now();
        return {27'd0, byte_ready, load, cpu_hold, done, error};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        cyc(gap);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = byte_ready;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_data  = 8'hA5;   // junk while not valid
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic send_image(input logic [31:0] n, input inst_t ws[$], input int gap);
        send_word(n, gap);
        foreach (ws[j]) send_word(ws[j], gap);
    endtask

    task automatic chk_writes(input string nm, input addr_t ga[$], input inst_t gd[$],
                              input addr_t ea[$], input inst_t ed[$]);
        chk({nm, "_count"}, ga.size(), ea.size());
        for (int j = 0; j < ea.size() && j < ga.size(); j++) begin
            chk($sformatf("%s_addr%0d", nm, j), ga[j], ea[j]);
            chk($sformatf("%s_inst%0d", nm, j), gd[j], ed[j]);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); ca.delete(); cd.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        // ---- reset state
        cyc(2);
        @(negedge clk);
        chk("reset_flags", flags_now(), 32'd0);
        chk("reset_addr", addr, 32'h0);
        chk("reset_inst", load_inst, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- nominal image, cycle by cycle; flags = {rdy, ld, hold, done, err}
        add(1, 0, 8'h00, 5'b00000, 32'h0, 32'h0);         // IDLE, start
        add(0, 1, 8'h02, 5'b10100, 32'h0, 32'h0);         // HDR
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
        add(0, 1, 8'h13, 5'b10100, 32'h0, 32'h0);         // DATA word 0
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
        add(0, 1, 8'h93, 5'b01100, 32'h0, 32'h00000013);  // WRITE, byte not taken
        add(0, 1, 8'h93, 5'b10100, 32'h0, 32'h00000013);  // DATA word 1
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h00000013);
        add(0, 1, 8'h10, 5'b10100, 32'h0, 32'h00000013);
        add(0, 1, 8'h00, 5'b10100, 32'h0, 32'h00000013);
        add(1, 0, 8'h00, 5'b01100, 32'h4, 32'h00100093);  // WRITE, start ignored
        add(0, 0, 8'h00, 5'b00010, 32'h4, 32'h00100093);  // DONE
        add(0, 0, 8'h00, 5'b00010, 32'h4, 32'h00100093);  // DONE sticky
        for (int k = 0; k < vt.size(); k++) begin
            start = vt[k].s; byte_valid = vt[k].v; byte_data = vt[k].d;
            @(negedge clk);
            chk($sformatf("vec%0d_flags", k), flags_now(), {27'd0, vt[k].flags});
            chk($sformatf("vec%0d_addr", k), addr, vt[k].a);
            chk($sformatf("vec%0d_inst", k), load_inst, vt[k].i);
            @(posedge clk); #1;
        end
        start = 1'b0; byte_valid = 1'b0;
        chk_writes("nominal", wa, wd, '{32'h0, 32'h4}, '{32'h00000013, 32'h00100093});

        // ---- gappy stream: valid 1,0,0,1,...
        clear_log();
        pulse_start();
        send_image(32'd2, '{32'h00000013, 32'h00100093}, 2);
        cyc(2);
        @(negedge clk);
        chk("gappy_flags", flags_now(), 32'b00010);
        chk_writes("gappy", wa, wd, '{32'h0, 32'h4}, '{32'h00000013, 32'h00100093});

        // ---- N = 0
        clear_log();
        pulse_start();
        send_word(32'd0, 0);
        cyc(1);
        @(negedge clk);
        chk("zero_flags", flags_now(), 32'b00010);
        chk("zero_writes", wa.size(), 32'd0);

        // ---- N = 17 with 16-word capacity
        clear_log();
        pulse_start();
        send_word(32'd17, 0);
        byte_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ovf_flags%0d", k), flags_now(), 32'b00001);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        chk("ovf_writes", wa.size(), 32'd0);

        // ---- reset after 2 bytes of word 1
        clear_log();
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'h00000013, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_flags", flags_now(), 32'd0);
        chk("rst_mid_addr", addr, 32'h0);
        chk("rst_mid_inst", load_inst, 32'h0);
        cyc(3);
        chk("rst_mid_writes", wa.size(), 32'd1);
        clear_log();
        pulse_start();
        send_image(32'd1, '{32'hDEADBEEF}, 0);
        cyc(2);
        @(negedge clk);
        chk("rst_reload_done", {31'd0, done}, 32'd1);
        chk_writes("rst_reload", wa, wd, '{32'h0}, '{32'hDEADBEEF});

        // ---- start during DATA is ignored
        clear_log();
        pulse_start();
        send_word(32'd1, 0);
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        pulse_start();
        @(negedge clk);
        chk("start_in_data_flags", flags_now(), 32'b10100);
        @(posedge clk); #1;
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        cyc(2);
        chk_writes("start_in_data", wa, wd, '{32'h0}, '{32'hA1B2C3D4});

        // ---- restart from DONE
        clear_log();
        @(negedge clk);
        chk("restart_pre_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("restart_hdr_flags", flags_now(), 32'b10100);
        @(posedge clk); #1;
        send_image(32'd1, '{32'h12345678}, 0);
        cyc(2);
        @(negedge clk);
        chk("restart_done", {31'd0, done}, 32'd1);
        chk_writes("restart", wa, wd, '{32'h0}, '{32'h12345678});

        // ---- full capacity on the 16-byte instance
        clear_log();
        pulse_start();
        send_image(32'd4, '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 0);
        cyc(2);
        @(negedge clk);
        chk("cap_full_done", {30'd0, c_done, c_error}, 32'b10);
        chk_writes("cap_full", ca, cd, '{32'h100, 32'h104, 32'h108, 32'h10C},
                   '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});

        // ---- one word over capacity: small instance errors, large one loads
        clear_log();
        pulse_start();
        send_image(32'd5, '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE}, 0);
        cyc(2);
        @(negedge clk);
        chk("cap_over_flags", {30'd0, c_done, c_error}, 32'b01);
        chk("cap_over_ready", {31'd0, c_ready}, 32'd0);
        chk("cap_over_writes", ca.size(), 32'd0);
        chk_writes("big_five", wa, wd, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10},
                   '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time program loader for the single-cycle MIPS core.
- Accepts a byte stream (valid/ready), parses a 4-byte word-count header, then assembles little-endian 32-bit instructions.
- Writes each instruction into instruction memory through its load/addr/load_inst write port.
- Holds the core in reset (cpu_hold) until the image is fully written.

Parameters:
- START_ADDR, InstStartFrom, byte address of the first instruction written; must be word-aligned.
- SPACE, InstSpace, instruction memory size in bytes; capacity = SPACE/4 words.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a load session; sampled only in IDLE, DONE or ERR.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  next byte of the stream.
- byte_ready  out  1  loader accepts byte_data this cycle; a transfer occurs when valid && ready.
- load  out  1  one-cycle write strobe to instruction memory.
- addr  out  32 (addr_t)  byte address of the word being written.
- load_inst  out  32 (inst_t)  instruction word being written.
- cpu_hold  out  1  high while a session is in progress (HDR, DATA, WRITE).
- done  out  1  image loaded successfully; sticky until start or rst.
- error  out  1  header count exceeded capacity; sticky until start or rst.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - load, byte_ready, cpu_hold, done and error are all 0.
  - addr = START_ADDR, load_inst = 0.
  - Byte counter, word counter and shift register are cleared.
  - Reset mid-session discards any partial word; no load pulse is issued on or after the reset edge.
- States:
  - IDLE: byte_ready=0. On start=1, go to HDR and clear the counters.
  - HDR: byte_ready=1. Collects 4 bytes; first byte is bits [7:0] (little-endian) of N = word count. After the 4th accepted byte:
    - N == 0 → DONE.
    - N > SPACE/4 → ERR.
    - Otherwise → DATA, with word index i = 0.
  - DATA: byte_ready=1. Collects 4 bytes, little-endian, into the shift register. When the 4th byte is accepted on the edge at cycle t, go to WRITE.
  - WRITE: exactly one cycle, during cycle t+1. Outputs:
    - byte_ready = 0 (a one-cycle bubble per word).
    - load = 1.
    - addr = START_ADDR + 4*i.
    - load_inst = assembled word.
    
    Then i increments. If i+1 == N → DONE, else → DATA.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start=1 → HDR (done clears the same edge).
  - ERR: error=1, cpu_hold=0, byte_ready=0; no memory write ever occurs. start=1 → HDR.
- Handshake rules:
  - A byte is consumed only on a cycle where byte_valid && byte_ready.
  - byte_valid low stalls assembly indefinitely, with no timeout.
  - byte_data is ignored when there is no transfer.
- start is ignored in HDR, DATA and WRITE.
- cpu_hold = 1 exactly in HDR, DATA and WRITE.
- Widths and arithmetic:
  - N is 32-bit unsigned; the capacity comparison is unsigned.
  - addr is computed as START_ADDR + (i << 2) with a 32-bit word counter.
  - No wrap is possible because N ≤ capacity is checked before any write.
- addr and load_inst hold their last written values outside WRITE. load is never high for two consecutive cycles.

Decomposition:
- Types package:
  - loader_state_t enum: IDLE, HDR, DATA, WRITE, DONE, ERR.
  - Existing addr_t and inst_t are reused.
- Parameters package: InstStartFrom and InstSpace supply the defaults; add LoaderHdrBytes = 4.
- Sub-module word_assembler:
  - Inputs: clk, rst, clear, shift_en, byte_in.
  - Outputs: 2-bit byte counter, word_full pulse, 32-bit word.
  - Little-endian shift. Used for both the header and the data words.

Test Plan:
- Nominal image: header N=2 (bytes 02 00 00 00), then 13 00 00 00 and 93 00 10 00, stream always valid, START_ADDR=0 → two load pulses:
  - addr=0x0, load_inst=0x00000013.
  - addr=0x4, load_inst=0x00100093.
  
  Each pulse occurs one cycle after its 4th byte. done=1 and cpu_hold=0 after the second write.
- Gappy stream: same image with byte_valid toggling 1,0,0,1,… → identical writes, word order and addresses. byte_ready=0 in each WRITE cycle.
- Zero/overflow header:
  - N=0 → DONE with no load pulse.
  - SPACE=64 with N=17 → error=1, no load pulse, byte_ready stays 0 despite byte_valid=1.
- Reset mid-word: rst asserted after 2 data bytes of word 1 → next cycle state is IDLE, no load, all outputs at reset values. A new start plus a full image then loads from addr=START_ADDR.
- Restart and start masking:
  - start pulsed during DATA is ignored (no state change).
  - start in DONE re-enters HDR, clears done, and reloads a new N=1 image to addr=START_ADDR.
- Full capacity: SPACE=16, N=4 → last write at addr=START_ADDR+0xC, then done=1, error=0.
